fdiv16_iter: RTL

- Iterative half-precision (fp16) divider computing x / y. It is the inverse-direction companion to the team's combinational fma16 datapath.
- It uses the same operand format, rounding-mode encoding and special-value conventions as fma16.
- Radix-2 restoring mantissa division runs one quotient bit per cycle, followed by a single rounding cycle.
- Sits beside fma16 in the fp16 exercise datapath behind a valid/ready handshake on both sides.

---
 rtl/fp16_pkg.sv | 48 ++++
 rtl/fp16_round.sv | 65 ++++++
 rtl/fdiv16_iter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 constants, operand view, rounding-mode encoding and FSM/flag encodings
// used by the fp16 arithmetic blocks (fdiv16_iter, fma16).
package fp16_pkg;

   localparam int          BIAS      = 15;
   localparam logic [15:0] NAN_CANON = 16'h7E00;
   localparam logic [14:0] MAXFIN    = 15'h7BFF;
   localparam logic [14:0] INF_MAG   = 15'h7C00;

   typedef enum logic [1:0] {
      RM_RZ  = 2'b00,
      RM_RNE = 2'b01,
      RM_RDN = 2'b10,
      RM_RUP = 2'b11
   } roundmode_t;

   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] frac;
   } fp16_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DIVIDE = 2'd1;
   localparam logic [1:0] ST_ROUND  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag vector
   localparam int FLG_NV = 4;
   localparam int FLG_DZ = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   function automatic logic is_nan(input fp16_t v);
      return (v.exp == 5'h1F) && (v.frac != 10'd0);
   endfunction

   function automatic logic is_inf(input fp16_t v);
      return (v.exp == 5'h1F) && (v.frac == 10'd0);
   endfunction

   // Subnormals are flushed: any zero exponent counts as zero
   function automatic logic is_zero(input fp16_t v);
      return v.exp == 5'd0;
   endfunction

endpackage

// File: rtl/fp16_round.sv
// fp16 rounder: normalized {sign, exp, 1.frac, guard, sticky} to packed fp16 plus OF/UF/NX.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module fp16_round
   import fp16_pkg::*;
(
   input  logic              sign,
   input  logic signed [6:0] exp_val,
   input  logic [10:0]       mant,
   input  logic              guard,
   input  logic              sticky,
   input  logic [1:0]        roundmode,
   output logic [15:0]       result,
   output logic              of_flag,
   output logic              uf_flag,
   output logic              nx_flag
);

   roundmode_t        rm;
   logic              inexact;
   logic              inc;
   logic [11:0]       mant_r;
   logic signed [6:0] exp_r;
   logic [9:0]        frac_r;

   assign rm      = roundmode_t'(roundmode);
   assign inexact = guard | sticky;

   always_comb begin
      inc = 1'b0;
      case (rm)
         RM_RNE:  inc = guard & (sticky | mant[0]);
         RM_RUP:  inc = ~sign & inexact;
         RM_RDN:  inc = sign & inexact;
         default: inc = 1'b0;
      endcase
   end

   // A carry out of the mantissa leaves 1.000..., so bump the exponent
   assign mant_r = {1'b0, mant} + {11'd0, inc};
   assign exp_r  = exp_val + {6'd0, mant_r[11]};
   assign frac_r = mant_r[11] ? mant_r[10:1] : mant_r[9:0];

   always_comb begin
      result  = {sign, exp_r[4:0], frac_r};
      of_flag = 1'b0;
      uf_flag = 1'b0;
      nx_flag = inexact;
      if (exp_r >= 7'sd31) begin
         of_flag = 1'b1;
         nx_flag = 1'b1;
         case (rm)
            RM_RZ:   result = {sign, MAXFIN};
            RM_RDN:  result = sign ? {1'b1, INF_MAG} : {1'b0, MAXFIN};
            RM_RUP:  result = sign ? {1'b1, MAXFIN}  : {1'b0, INF_MAG};
            default: result = {sign, INF_MAG};
         endcase
      end else if (exp_r <= 7'sd0) begin
         uf_flag = 1'b1;
         nx_flag = 1'b1;
         result  = {sign, 15'd0};
      end
   end

endmodule

// File: rtl/fdiv16_iter.sv
// Iterative fp16 divider x / y: restoring radix-2 mantissa loop, then one rounding cycle.
// Latency: QBITS+2 cycles accept-to-valid for finite operands, 1 cycle for special operands.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fdiv16_iter
   import fp16_pkg::*;
#(
   parameter int QBITS = 13
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [1:0]  roundmode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic [4:0]  flags
);

   localparam int CW = $clog2(QBITS);

   logic [1:0]        state;
   logic              sign_q;
   logic signed [6:0] exp_q;
   logic [1:0]        rm_q;
   logic [11:0]       rem_q;
   logic [10:0]       div_q;
   logic [QBITS-1:0]  q_q;
   logic [CW-1:0]     cnt_q;
   logic [15:0]       result_q;
   logic [4:0]        flags_q;

   fp16_t             xs, ys;
   logic              x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
   logic              sign_in;
   logic signed [6:0] exp_in;
   logic              spec_hit;
   logic [15:0]       spec_res;
   logic [4:0]        spec_flags;

   assign xs      = x;
   assign ys      = y;
   assign x_nan   = is_nan(xs);
   assign y_nan   = is_nan(ys);
   assign x_inf   = is_inf(xs);
   assign y_inf   = is_inf(ys);
   assign x_zero  = is_zero(xs);
   assign y_zero  = is_zero(ys);
   assign sign_in = xs.sign ^ ys.sign;
   assign exp_in  = {2'b00, xs.exp} - {2'b00, ys.exp} + 7'(BIAS);

   // Only signaling NaNs (quiet bit clear) raise NV; quiet NaNs propagate silently
   always_comb begin
      spec_hit   = 1'b1;
      spec_res   = 16'h0000;
      spec_flags = 5'b0;
      if (x_nan | y_nan) begin
         spec_res           = NAN_CANON;
         spec_flags[FLG_NV] = (x_nan & ~xs.frac[9]) | (y_nan & ~ys.frac[9]);
      end else if ((x_zero & y_zero) | (x_inf & y_inf)) begin
         spec_res           = NAN_CANON;
         spec_flags[FLG_NV] = 1'b1;
      end else if (x_inf) begin
         spec_res = {sign_in, INF_MAG};
      end else if (y_zero) begin
         spec_res           = {sign_in, INF_MAG};
         spec_flags[FLG_DZ] = 1'b1;
      end else if (y_inf | x_zero) begin
         spec_res = {sign_in, 15'd0};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // Restoring step; rem stays below 2*div so 12 bits never overflow
   logic              rem_ge;
   logic [10:0]       rem_diff;
   logic [11:0]       rem_nxt;

   assign rem_ge   = rem_q >= {1'b0, div_q};
   assign rem_diff = rem_q[10:0] - div_q;
   assign rem_nxt  = rem_ge ? {rem_diff, 1'b0} : {rem_q[10:0], 1'b0};

   logic [QBITS-1:0]  q_norm;
   logic signed [6:0] exp_norm;
   logic [10:0]       r_mant;
   logic              r_guard;
   logic              r_sticky;
   logic [15:0]       rnd_res;
   logic              rnd_of, rnd_uf, rnd_nx;

   assign q_norm   = q_q[QBITS-1] ? q_q : {q_q[QBITS-2:0], 1'b0};
   assign exp_norm = q_q[QBITS-1] ? exp_q : exp_q - 7'sd1;
   assign r_mant   = q_norm[QBITS-1 -: 11];
   assign r_guard  = q_norm[QBITS-12];
   assign r_sticky = (|q_norm[QBITS-13:0]) | (|rem_q);

   fp16_round u_round (
      .sign      (sign_q),
      .exp_val   (exp_norm),
      .mant      (r_mant),
      .guard     (r_guard),
      .sticky    (r_sticky),
      .roundmode (rm_q),
      .result    (rnd_res),
      .of_flag   (rnd_of),
      .uf_flag   (rnd_uf),
      .nx_flag   (rnd_nx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         rm_q     <= 2'b00;
         rem_q    <= '0;
         div_q    <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         result_q <= 16'h0000;
         flags_q  <= 5'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sign_q <= sign_in;
                  exp_q  <= exp_in;
                  rm_q   <= roundmode;
                  rem_q  <= {1'b0, 1'b1, xs.frac};
                  div_q  <= {1'b1, ys.frac};
                  q_q    <= '0;
                  cnt_q  <= '0;
                  if (spec_hit) begin
                     result_q <= spec_res;
                     flags_q  <= spec_flags;
                     state    <= ST_DONE;
                  end else begin
                     state <= ST_DIVIDE;
                  end
               end
            end
            ST_DIVIDE: begin
               rem_q <= rem_nxt;
               q_q   <= {q_q[QBITS-2:0], rem_ge};
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(QBITS-1))
                  state <= ST_ROUND;
            end
            ST_ROUND: begin
               result_q <= rnd_res;
               flags_q  <= {2'b00, rnd_of, rnd_uf, rnd_nx};
               state    <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule
